wb_regs_slave: RTL and testbench

Pipelined-mode Wishbone responder serving a small memory-mapped register window. It is the slave end of the bus driven by the UART-command Wishbone master. It provides ID, LED control, user-button status, a free-running cycle counter and scratch registers, with programmable wait states so master stall and ack handling can be exercised on hardware.

---
 rtl/wb_regs_pkg.sv | 35 +++
 rtl/wb_regs_slave_btn_sync.sv | 34 +++
 rtl/wb_regs_slave.sv | 209 ++++++++++++++++++++
 tb/tb_wb_regs_slave.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_regs_pkg.sv
// Shared definitions for the Wishbone register window: word offsets,
// STATUS bit positions, default ID word, FSM state encoding and a
// byte-lane merge helper used by the masked-write registers.
package wb_regs_pkg;

  localparam logic [31:0] ID_DEFAULT = 32'h5742_0001;

  localparam int REG_ID       = 0;
  localparam int REG_CTRL     = 1;
  localparam int REG_STATUS   = 2;
  localparam int REG_CYCLES   = 3;
  localparam int REG_SCRATCH0 = 4;

  localparam int STATUS_PRESSED_BIT = 0;
  localparam int STATUS_STICKY_BIT  = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Replace only the byte lanes whose select bit is set.
  function automatic logic [31:0] apply_sel(input logic [31:0] old_w,
                                            input logic [31:0] new_w,
                                            input logic [3:0]  sel);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/wb_regs_slave_btn_sync.sv
// btn_sync: 2-flop synchronizer for an active-low button plus a one-cycle
// pulse on the released->pressed edge of the synchronized level.
// Latency: o_pressed lags the pin by 2-3 clocks; no backpressure.
// Ports: i_clk, i_reset_n (async, active low), i_btn_n (raw pin, low =
// pressed), o_pressed (synchronized level), o_press_pulse (edge pulse).
module btn_sync (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_btn_n,
  output logic o_pressed,
  output logic o_press_pulse
);

  logic meta_q;
  logic sync_q;
  logic pressed_prev_q;

  // Reset to "released" so no spurious press edge leaves reset.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      meta_q         <= 1'b1;
      sync_q         <= 1'b1;
      pressed_prev_q <= 1'b0;
    end else begin
      meta_q         <= i_btn_n;
      sync_q         <= meta_q;
      pressed_prev_q <= ~sync_q;
    end
  end

  assign o_pressed     = ~sync_q;
  assign o_press_pulse = ~sync_q & ~pressed_prev_q;

endmodule

// File: rtl/wb_regs_slave.sv
// wb_regs_slave: pipelined Wishbone responder for an NREGS-word register
// window (ID, CTRL->LEDs, STATUS, CYCLES, scratch).
// Latency: ack/err WAIT_STATES+1 clocks after the accept edge.
// Backpressure: stall is high for the whole WAIT/RESP span; one request in flight.
// Ports: i_clk, i_reset_n, Wishbone slave (i_wb_* / o_wb_*), i_usr_button
// (low = pressed), o_LEDS. Macro WB_REGS_ERR_EN turns unmapped accesses
// into err completions instead of ack-with-zero.
module wb_regs_slave
  import wb_regs_pkg::*;
#(
  parameter int          NREGS       = 8,
  parameter logic [29:0] BASE_ADDR   = 30'h0,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] ID_VALUE    = ID_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [29:0] i_wb_addr,
  input  logic [31:0] i_wb_data,
  input  logic [3:0]  i_wb_sel,
  output logic        o_wb_stall,
  output logic        o_wb_ack,
  output logic        o_wb_err,
  output logic [31:0] o_wb_data,
  input  logic        i_usr_button,
  output logic [7:0]  o_LEDS
);

  localparam int AW   = $clog2(NREGS);
  localparam int NSCR = NREGS - REG_SCRATCH0;
  localparam logic [3:0] WS_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

`ifdef WB_REGS_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;

  logic          we_q, hit_q;
  logic [AW-1:0] off_q;
  logic [31:0]   dat_q;
  logic [3:0]    sel_q;

  logic [7:0]    ctrl_q;
  logic          sticky_q;
  logic [31:0]   cycles_q;
  logic [31:0]   scratch_q [NSCR];
  logic [31:0]   rdata_q;
  logic          err_q;

  logic          pressed, press_pulse;
  logic          accept, enter_resp, wr_en;
  logic          c_we, c_hit;
  logic [AW-1:0] c_off;
  logic [31:0]   c_dat, rd_d;
  logic [3:0]    c_sel;
  logic          err_d;

  btn_sync u_btn_sync (
    .i_clk         (i_clk),
    .i_reset_n     (i_reset_n),
    .i_btn_n       (i_usr_button),
    .o_pressed     (pressed),
    .o_press_pulse (press_pulse)
  );

  assign accept     = (state_q == IDLE) && i_wb_cyc && i_wb_stb;
  assign enter_resp = (state_d == RESP);

  // With zero wait states the commit edge is the accept edge itself, so the
  // request is taken straight from the bus; otherwise from the latched copy.
  always_comb begin
    if (state_q == IDLE) begin
      c_we  = i_wb_we;
      c_hit = (i_wb_addr[29:AW] == BASE_ADDR[29:AW]);
      c_off = i_wb_addr[AW-1:0];
      c_dat = i_wb_data;
      c_sel = i_wb_sel;
    end else begin
      c_we  = we_q;
      c_hit = hit_q;
      c_off = off_q;
      c_dat = dat_q;
      c_sel = sel_q;
    end
  end

  assign wr_en = enter_resp && c_we && c_hit;
  assign err_d = ERR_EN && !c_hit;

  // FSM: state register
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM: next state. Dropping cyc while waiting abandons the request.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (WAIT_STATES == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = WS_LOAD;
          end
        end
      end
      WAIT: begin
        if (!i_wb_cyc)          state_d = IDLE;
        else if (cnt_q == 4'd0) state_d = RESP;
        else                    cnt_d   = cnt_q - 4'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    o_wb_stall = (state_q != IDLE);
    o_wb_ack   = (state_q == RESP) && !err_q;
    o_wb_err   = (state_q == RESP) && err_q;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      we_q  <= 1'b0;
      hit_q <= 1'b0;
      off_q <= '0;
      dat_q <= '0;
      sel_q <= '0;
    end else if (accept) begin
      we_q  <= i_wb_we;
      hit_q <= (i_wb_addr[29:AW] == BASE_ADDR[29:AW]);
      off_q <= i_wb_addr[AW-1:0];
      dat_q <= i_wb_data;
      sel_q <= i_wb_sel;
    end
  end

  // Read mux; unmapped addresses read as zero.
  always_comb begin
    rd_d = '0;
    if (c_hit) begin
      if (c_off == AW'(REG_ID)) begin
        rd_d = ID_VALUE;
      end else if (c_off == AW'(REG_CTRL)) begin
        rd_d[7:0] = ctrl_q;
      end else if (c_off == AW'(REG_STATUS)) begin
        rd_d[STATUS_PRESSED_BIT] = pressed;
        rd_d[STATUS_STICKY_BIT]  = sticky_q;
      end else if (c_off == AW'(REG_CYCLES)) begin
        rd_d = cycles_q;
      end else begin
        for (int i = 0; i < NSCR; i++) begin
          if (c_off == AW'(REG_SCRATCH0 + i)) rd_d = scratch_q[i];
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ctrl_q   <= '0;
      sticky_q <= 1'b0;
      cycles_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < NSCR; i++) scratch_q[i] <= '0;
    end else begin
      cycles_q <= cycles_q + 32'd1;
      if (wr_en && c_off == AW'(REG_CTRL) && c_sel[0]) ctrl_q <= c_dat[7:0];
      // A new press beats a simultaneous write-1-to-clear.
      if (press_pulse) begin
        sticky_q <= 1'b1;
      end else if (wr_en && c_off == AW'(REG_STATUS) && c_sel[0] &&
                   c_dat[STATUS_STICKY_BIT]) begin
        sticky_q <= 1'b0;
      end
      for (int i = 0; i < NSCR; i++) begin
        if (wr_en && c_off == AW'(REG_SCRATCH0 + i))
          scratch_q[i] <= apply_sel(scratch_q[i], c_dat, c_sel);
      end
      if (enter_resp) begin
        rdata_q <= rd_d;
        err_q   <= err_d;
      end
    end
  end

  assign o_wb_data = rdata_q;
  assign o_LEDS    = ctrl_q;

endmodule

// File: tb/tb_wb_regs_slave.sv
// Directed bench for wb_regs_slave: three instances with 0, 3 and 5 wait
// states share the bus data lines and reset; each has its own cyc line.
module tb_wb_regs_slave;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cyc [3];
  logic        stb, we;
  logic [29:0] addr;
  logic [31:0] wdat;
  logic [3:0]  sel;
  logic        button;

  logic        stall [3];
  logic        ack   [3];
  logic        err   [3];
  logic [31:0] rdat  [3];
  logic [7:0]  leds  [3];

  int total = 0;
  int bad   = 0;

  logic [31:0] rd, rd2;
  logic        ak, er;
  int          lat;
  int          seen;

  always #5 clk = ~clk;

  wb_regs_slave #(.NREGS(8), .BASE_ADDR(30'h0), .WAIT_STATES(0)) dut0 (
    .i_clk(clk), .i_reset_n(rst_n), .i_wb_cyc(cyc[0]), .i_wb_stb(stb), .i_wb_we(we),
    .i_wb_addr(addr), .i_wb_data(wdat), .i_wb_sel(sel), .o_wb_stall(stall[0]),
    .o_wb_ack(ack[0]), .o_wb_err(err[0]), .o_wb_data(rdat[0]),
    .i_usr_button(button), .o_LEDS(leds[0]));

  wb_regs_slave #(.NREGS(8), .BASE_ADDR(30'h0), .WAIT_STATES(3)) dut1 (
    .i_clk(clk), .i_reset_n(rst_n), .i_wb_cyc(cyc[1]), .i_wb_stb(stb), .i_wb_we(we),
    .i_wb_addr(addr), .i_wb_data(wdat), .i_wb_sel(sel), .o_wb_stall(stall[1]),
    .o_wb_ack(ack[1]), .o_wb_err(err[1]), .o_wb_data(rdat[1]),
    .i_usr_button(button), .o_LEDS(leds[1]));

  wb_regs_slave #(.NREGS(8), .BASE_ADDR(30'h0), .WAIT_STATES(5)) dut2 (
    .i_clk(clk), .i_reset_n(rst_n), .i_wb_cyc(cyc[2]), .i_wb_stb(stb), .i_wb_we(we),
    .i_wb_addr(addr), .i_wb_data(wdat), .i_wb_sel(sel), .o_wb_stall(stall[2]),
    .o_wb_ack(ack[2]), .o_wb_err(err[2]), .o_wb_data(rdat[2]),
    .i_usr_button(button), .o_LEDS(leds[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete transfer on instance d. lat counts clock edges from the
  // accept edge up to the edge at which the master samples ack/err.
  task automatic xfer(input int d, input logic w, input logic [29:0] a,
                      input logic [31:0] wd, input logic [3:0] s,
                      output logic [31:0] r, output logic k, output logic e,
                      output int l);
    @(negedge clk);
    cyc[d] = 1'b1; stb = 1'b1; we = w; addr = a; wdat = wd; sel = s;
    @(posedge clk); #1;
    stb = 1'b0;
    l = 1;
    while (!(ack[d] || err[d]) && l < 40) begin
      @(posedge clk); #1;
      l++;
    end
    r = rdat[d]; k = ack[d]; e = err[d];
    @(posedge clk); #1;
    cyc[d] = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; button = 1'b1; stb = 1'b0; we = 1'b0;
    addr = '0; wdat = '0; sel = '0;
    for (int i = 0; i < 3; i++) cyc[i] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_stall", {31'd0, stall[0]}, 32'd0);
    chk("rst_ack",   {31'd0, ack[0]},   32'd0);
    chk("rst_err",   {31'd0, err[0]},   32'd0);
    chk("rst_data",  rdat[0], 32'd0);
    chk("rst_leds",  {24'd0, leds[0]}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // ID read, zero wait states, with stall profile around it.
    @(negedge clk);
    cyc[0] = 1'b1; stb = 1'b1; we = 1'b0; addr = 30'd0; sel = 4'hF;
    chk("id_stall_idle", {31'd0, stall[0]}, 32'd0);
    @(posedge clk); #1;
    stb = 1'b0;
    chk("id_ack",        {31'd0, ack[0]},   32'd1);
    chk("id_stall_resp", {31'd0, stall[0]}, 32'd1);
    chk("id_data",       rdat[0], 32'h5742_0001);
    @(posedge clk); #1;
    cyc[0] = 1'b0;
    chk("id_ack_one",     {31'd0, ack[0]},   32'd0);
    chk("id_stall_after", {31'd0, stall[0]}, 32'd0);
    chk("id_data_hold",   rdat[0], 32'h5742_0001);

    // CTRL drives LEDs; only byte 0 is stored.
    xfer(0, 1'b1, 30'd1, 32'h0000_00A5, 4'h1, rd, ak, er, lat);
    chk("ctrl_w_ack", {31'd0, ak}, 32'd1);
    chk("ctrl_w_lat", lat, 32'd1);
    chk("ctrl_leds",  {24'd0, leds[0]}, 32'h0000_00A5);
    xfer(0, 1'b0, 30'd1, 32'd0, 4'hF, rd, ak, er, lat);
    chk("ctrl_rd", rd, 32'h0000_00A5);
    xfer(0, 1'b1, 30'd1, 32'hFFFF_FF3C, 4'hF, rd, ak, er, lat);
    xfer(0, 1'b0, 30'd1, 32'd0, 4'hF, rd, ak, er, lat);
    chk("ctrl_rd_upper0", rd, 32'h0000_003C);
    xfer(0, 1'b1, 30'd1, 32'h0000_00A5, 4'h1, rd, ak, er, lat);

    // Read-only registers ignore writes but still ack.
    xfer(0, 1'b1, 30'd0, 32'hFFFF_FFFF, 4'hF, rd, ak, er, lat);
    chk("id_w_ack", {31'd0, ak}, 32'd1);
    xfer(0, 1'b0, 30'd0, 32'd0, 4'hF, rd, ak, er, lat);
    chk("id_ro", rd, 32'h5742_0001);

    // Free-running cycle counter advances between reads.
    xfer(0, 1'b0, 30'd3, 32'd0, 4'hF, rd, ak, er, lat);
    xfer(0, 1'b0, 30'd3, 32'd0, 4'hF, rd2, ak, er, lat);
    chk("cycles_adv",   {31'd0, (rd2 > rd)}, 32'd1);
    chk("cycles_small", {31'd0, ((rd2 - rd) < 32'd20)}, 32'd1);

    // Three wait states: scratch byte-masked writes.
    xfer(1, 1'b1, 30'd4, 32'hDEAD_BEEF, 4'hF, rd, ak, er, lat);
    chk("ws3_w1_lat", lat, 32'd4);
    chk("ws3_w1_ack", {31'd0, ak}, 32'd1);
    xfer(1, 1'b1, 30'd4, 32'h0000_1200, 4'h2, rd, ak, er, lat);
    chk("ws3_w2_lat", lat, 32'd4);
    xfer(1, 1'b0, 30'd4, 32'd0, 4'hF, rd, ak, er, lat);
    chk("ws3_rd", rd, 32'hDEAD_12EF);
    chk("ws3_rd_lat", lat, 32'd4);

    // Button press: level and sticky flag, then write-1-to-clear.
    @(negedge clk); button = 1'b0;
    repeat (10) @(posedge clk);
    xfer(0, 1'b0, 30'd2, 32'd0, 4'hF, rd, ak, er, lat);
    chk("status_pressed", rd, 32'h0000_0003);
    @(negedge clk); button = 1'b1;
    repeat (5) @(posedge clk);
    xfer(0, 1'b0, 30'd2, 32'd0, 4'hF, rd, ak, er, lat);
    chk("status_sticky", rd, 32'h0000_0002);
    xfer(0, 1'b1, 30'd2, 32'h0000_0002, 4'hF, rd, ak, er, lat);
    xfer(0, 1'b0, 30'd2, 32'd0, 4'hF, rd, ak, er, lat);
    chk("status_clr", rd, 32'h0000_0000);

    // Decode miss: offset 8 lies outside an 8-word window at base 0.
    xfer(0, 1'b0, 30'd8, 32'd0, 4'hF, rd, ak, er, lat);
`ifdef WB_REGS_ERR_EN
    chk("miss_err", {31'd0, er}, 32'd1);
    chk("miss_ack", {31'd0, ak}, 32'd0);
`else
    chk("miss_ack",  {31'd0, ak}, 32'd1);
    chk("miss_err",  {31'd0, er}, 32'd0);
    chk("miss_data", rd, 32'd0);
`endif
    xfer(0, 1'b1, 30'd12, 32'h1234_5678, 4'hF, rd, ak, er, lat);
    xfer(0, 1'b0, 30'd4, 32'd0, 4'hF, rd, ak, er, lat);
    chk("miss_no_alias", rd, 32'd0);

    // Abort: drop cyc after two wait cycles of a five-wait write.
    @(negedge clk);
    cyc[2] = 1'b1; stb = 1'b1; we = 1'b1; addr = 30'd5; wdat = 32'hCAFE_F00D; sel = 4'hF;
    @(posedge clk); #1;
    stb = 1'b0;
    chk("abort_stall", {31'd0, stall[2]}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    cyc[2] = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (ack[2] || err[2]) seen++;
    end
    chk("abort_no_resp", seen, 32'd0);
    chk("abort_idle",    {31'd0, stall[2]}, 32'd0);
    xfer(2, 1'b0, 30'd5, 32'd0, 4'hF, rd, ak, er, lat);
    chk("abort_no_write", rd, 32'd0);
    chk("ws5_lat", lat, 32'd6);

    // Reset in the middle of a wait.
    xfer(0, 1'b0, 30'd0, 32'd0, 4'hF, rd, ak, er, lat);
    @(negedge clk);
    cyc[2] = 1'b1; stb = 1'b1; we = 1'b1; addr = 30'd6; wdat = 32'h1111_1111; sel = 4'hF;
    @(posedge clk); #1;
    stb = 1'b0;
    @(posedge clk); #2;
    chk("mid_stall_pre", {31'd0, stall[2]}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_stall", {31'd0, stall[2]}, 32'd0);
    chk("mid_rst_ack",   {31'd0, ack[2]},   32'd0);
    chk("mid_rst_err",   {31'd0, err[2]},   32'd0);
    chk("mid_rst_data",  rdat[0], 32'd0);
    chk("mid_rst_leds",  {24'd0, leds[0]}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    cyc[2] = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (ack[2] || err[2]) seen++;
    end
    chk("mid_rst_no_resp", seen, 32'd0);
    xfer(2, 1'b0, 30'd6, 32'd0, 4'hF, rd, ak, er, lat);
    chk("mid_rst_no_write", rd, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
